// File: rtl/fighter_ctrl_if.sv
// Fighter controller frame-side bus: per-frame controls in,
// fighter position/state out. Slave side is the controller.
interface fighter_ctrl_if #(
  parameter int X_W   = 10,
  parameter int CNT_W = 5
);
  logic             frame_tick;
  logic             btn_left;
  logic             btn_right;
  logic             btn_attack;
  logic             hit_in;
  logic [X_W-1:0]   x_pos;
  logic [2:0]       state;
  logic [CNT_W-1:0] phase_frame;
  logic             hit_active;
  logic             busy;

  modport master (
    output frame_tick, btn_left, btn_right,
    output btn_attack, hit_in,
    input  x_pos, state, phase_frame,
    input  hit_active, busy
  );

  modport slave (
    input  frame_tick, btn_left, btn_right,
    input  btn_attack, hit_in,
    output x_pos, state, phase_frame,
    output hit_active, busy
  );
endinterface

// File: rtl/fighter_ctrl.sv
// Per-player fighter FSM: walk, 3-phase attack, hitstun.
// Optional blocking (BLOCKSTUN) enabled by FIGHTER_BLOCK_EN.
module fighter_ctrl #(
  parameter int X_W           = 10,
  parameter int SCREEN_W      = 640,
  parameter int SPRITE_W      = 64,
  parameter int START_X       = 10,
  parameter int FWD_STEP      = 3,
  parameter int BWD_STEP      = 2,
  parameter int FACING_RIGHT  = 1,
  parameter int CNT_W         = 5,
  parameter int ATK_STARTUP   = 5,
  parameter int ATK_ACTIVE    = 2,
  parameter int ATK_RECOVERY  = 16,
  parameter int HITSTUN_LEN   = 15,
  parameter int BLOCKSTUN_LEN = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  fighter_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_FWD  = 3'd1,
    MOVE_BWD  = 3'd2,
    ATK_SU    = 3'd3,
    ATK_ACT   = 3'd4,
    ATK_REC   = 3'd5,
    HITSTUN   = 3'd6,
    BLOCKSTUN = 3'd7
  } st_t;

  localparam int XW1 = X_W + 1;
  localparam logic [X_W:0] MAX_X = XW1'(SCREEN_W - SPRITE_W);
  localparam logic [X_W:0] FS = XW1'(FWD_STEP);
  localparam logic [X_W:0] BS = XW1'(BWD_STEP);

  localparam logic [CNT_W-1:0] SU_LAST  = CNT_W'(ATK_STARTUP - 1);
  localparam logic [CNT_W-1:0] ACT_LAST = CNT_W'(ATK_ACTIVE - 1);
  localparam logic [CNT_W-1:0] REC_LAST = CNT_W'(ATK_RECOVERY - 1);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(HITSTUN_LEN - 1);
  localparam logic [CNT_W-1:0] BS_LAST  = CNT_W'(BLOCKSTUN_LEN - 1);

  st_t              st, nxt;
  logic [CNT_W-1:0] ph;
  logic [X_W-1:0]   x, x_nxt;
  logic             ha, bz;
  logic             restart;
  logic             fwd_raw, bwd_raw, fwd, bwd, blk;
  logic             mv, right;
  logic [X_W:0]     xe, amt, sum;

  assign fwd_raw = (FACING_RIGHT != 0) ? bus.btn_right : bus.btn_left;
  assign bwd_raw = (FACING_RIGHT != 0) ? bus.btn_left : bus.btn_right;
  assign fwd = fwd_raw & ~bwd_raw;
  assign bwd = bwd_raw & ~fwd_raw;

`ifdef FIGHTER_BLOCK_EN
  assign blk = (st == MOVE_BWD) || ((st == IDLE) && bwd);
`else
  assign blk = 1'b0;
`endif

  // Saturating move based on the state held during this frame
  always_comb begin
    mv    = (st == MOVE_FWD) || (st == MOVE_BWD);
    right = (st == MOVE_FWD) == (FACING_RIGHT != 0);
    amt   = (st == MOVE_FWD) ? FS : BS;
    xe    = {1'b0, x};
    sum   = xe + amt;
    x_nxt = x;
    if (mv) begin
      if (right)
        x_nxt = (sum > MAX_X) ? MAX_X[X_W-1:0] : sum[X_W-1:0];
      else
        x_nxt = (xe < amt) ? '0 : X_W'(xe - amt);
    end
  end

  // Next-state decode; restart clears phase_frame
  always_comb begin
    nxt     = st;
    restart = 1'b0;
    unique case (st)
      IDLE, MOVE_FWD, MOVE_BWD: begin
        if (bus.hit_in)          nxt = blk ? BLOCKSTUN : HITSTUN;
        else if (bus.btn_attack) nxt = ATK_SU;
        else if (fwd)            nxt = MOVE_FWD;
        else if (bwd)            nxt = MOVE_BWD;
        else                     nxt = IDLE;
      end
      ATK_SU: begin
        if (bus.hit_in)          nxt = HITSTUN;
        else if (ph == SU_LAST)  nxt = ATK_ACT;
      end
      ATK_ACT: begin
        if (ph == ACT_LAST)      nxt = ATK_REC;
      end
      ATK_REC: begin
        if (bus.hit_in)          nxt = HITSTUN;
        else if (ph == REC_LAST) nxt = IDLE;
      end
      HITSTUN: begin
        if (bus.hit_in)          restart = 1'b1;
        else if (ph == HS_LAST)  nxt = IDLE;
      end
      BLOCKSTUN: begin
`ifdef FIGHTER_BLOCK_EN
        if (bus.hit_in)          restart = 1'b1;
        else if (ph == BS_LAST)  nxt = IDLE;
`else
        if (ph == BS_LAST)       nxt = IDLE;
`endif
      end
      default:                   nxt = IDLE;
    endcase
    if (nxt != st) restart = 1'b1;
  end

  // Frame-rate state, position, phase and decoded outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st <= IDLE;
      x  <= X_W'(START_X);
      ph <= '0;
      ha <= 1'b0;
      bz <= 1'b0;
    end else if (bus.frame_tick) begin
      st <= nxt;
      x  <= x_nxt;
      ph <= restart ? '0 : ph + 1'b1;
      ha <= (nxt == ATK_ACT);
      bz <= (nxt == ATK_SU) || (nxt == ATK_ACT) ||
            (nxt == ATK_REC) || (nxt == HITSTUN) ||
            (nxt == BLOCKSTUN);
    end
  end

  assign bus.state       = st;
  assign bus.x_pos       = x;
  assign bus.phase_frame = ph;
  assign bus.hit_active  = ha;
  assign bus.busy        = bz;

endmodule

// File: tb/tb_fighter_ctrl.sv
// Scoreboard bench for fighter_ctrl: frame-level reference
// model feeds an expectation queue drained by a monitor.
module tb_fighter_ctrl;

  typedef struct packed {
    logic [2:0] st;
    logic [9:0] x;
    logic [4:0] ph;
    logic       ha;
    logic       bz;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  bit   mon_on = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t q[$];
  exp_t cur;

  int m_st, m_ph, m_x;

  fighter_ctrl_if #(.X_W(10), .CNT_W(5)) bus ();

  fighter_ctrl dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic int stlen(input int s);
    case (s)
      3: return 5;
      4: return 2;
      5: return 16;
      6: return 15;
      7: return 10;
      default: return 0;
    endcase
  endfunction

  function automatic int succ(input int s);
    case (s)
      3: return 4;
      4: return 5;
      default: return 0;
    endcase
  endfunction

  function automatic exp_t snap();
    exp_t e;
    e.st = 3'(m_st);
    e.x  = 10'(m_x);
    e.ph = 5'(m_ph);
    e.ha = (m_st == 4);
    e.bz = (m_st >= 3);
    return e;
  endfunction

  task automatic model_reset();
    m_st = 0;
    m_ph = 0;
    m_x  = 10;
  endtask

  // One game frame from the rule book (facing right)
  task automatic model_step(input bit l, r, a, h);
    bit fw, bw, blk, again;
    int nst;
    fw = r && !l;
    bw = l && !r;
    if (m_st == 1) m_x = m_x + 3;
    if (m_st == 2) m_x = m_x - 2;
    if (m_x > 576) m_x = 576;
    if (m_x < 0) m_x = 0;
    blk = 0;
`ifdef FIGHTER_BLOCK_EN
    blk = (m_st == 2) || (m_st == 0 && bw);
`endif
    again = 0;
    if (m_st <= 2) begin
      if (h)       nst = blk ? 7 : 6;
      else if (a)  nst = 3;
      else if (fw) nst = 1;
      else if (bw) nst = 2;
      else         nst = 0;
    end else if (h && (m_st == 3 || m_st == 5)) begin
      nst = 6;
    end else if (h && m_st == 6) begin
      nst = 6;
      again = 1;
`ifdef FIGHTER_BLOCK_EN
    end else if (h && m_st == 7) begin
      nst = 7;
      again = 1;
`endif
    end else if (m_ph == stlen(m_st) - 1) begin
      nst = succ(m_st);
    end else begin
      nst = m_st;
    end
    if (again || nst != m_st) m_ph = 0;
    else m_ph = (m_ph + 1) % 32;
    m_st = nst;
  endtask

  task automatic chk(input string nm, input exp_t e);
    total++;
    if (bus.state !== e.st || bus.x_pos !== e.x ||
        bus.phase_frame !== e.ph ||
        bus.hit_active !== e.ha || bus.busy !== e.bz) begin
      bad++;
      $display("FAIL %s t=%0t got st=%0d x=%0d ph=%0d ha=%0d bz=%0d want st=%0d x=%0d ph=%0d ha=%0d bz=%0d",
               nm, $time, bus.state, bus.x_pos, bus.phase_frame,
               bus.hit_active, bus.busy,
               e.st, e.x, e.ph, e.ha, e.bz);
    end
  endtask

  // Monitor: pop on every frame tick, check hold otherwise
  always @(posedge clk) begin : mon
    logic tk;
    tk = bus.frame_tick;
    #1;
    if (mon_on && reset_n) begin
      if (tk) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL underflow: tick with empty queue");
        end else begin
          cur = q.pop_front();
        end
        chk("tick", cur);
      end else begin
        chk("hold", cur);
      end
    end
  end

  task automatic tick(input bit l, r, a, h);
    @(negedge clk);
    bus.btn_left   = l;
    bus.btn_right  = r;
    bus.btn_attack = a;
    bus.hit_in     = h;
    bus.frame_tick = 1'b1;
    model_step(l, r, a, h);
    q.push_back(snap());
    @(negedge clk);
    bus.frame_tick = 1'b0;
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic hold(input int n, input bit l, r, a);
    for (int i = 0; i < n; i++) tick(l, r, a, 1'b0);
  endtask

  task automatic run_until(input int s, input int p);
    int n;
    n = 0;
    while (!(m_st == s && m_ph == p) && n < 100) begin
      tick(0, 0, 0, 0);
      n++;
    end
    if (n >= 100) begin
      bad++;
      $display("FAIL wait st=%0d ph=%0d timed out", s, p);
    end
  endtask

  initial begin
    exp_t e;
    bus.frame_tick = 0;
    bus.btn_left   = 0;
    bus.btn_right  = 0;
    bus.btn_attack = 0;
    bus.hit_in     = 0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cur = snap();
    mon_on = 1'b1;

    hold(3, 0, 0, 0);
    hold(4, 0, 1, 0);
    hold(2, 0, 0, 0);
    tick(0, 0, 1, 0);
    hold(28, 0, 0, 0);

    hold(15, 1, 0, 0);
    hold(2, 0, 0, 0);
    hold(2, 0, 1, 0);
    tick(0, 0, 0, 0);
    hold(2, 1, 0, 0);
    tick(0, 0, 0, 0);
    hold(200, 0, 1, 0);
    hold(2, 1, 1, 0);
    tick(0, 0, 0, 0);

    tick(0, 0, 1, 0);
    run_until(5, 3);
    tick(0, 0, 0, 1);
    run_until(6, 10);
    tick(0, 0, 0, 1);
    hold(18, 0, 0, 0);

    tick(0, 0, 1, 0);
    run_until(4, 0);
    tick(0, 0, 0, 1);
    hold(20, 0, 0, 0);

    hold(3, 1, 0, 0);
    tick(1, 0, 0, 1);
    hold(4, 1, 0, 0);
    tick(1, 0, 0, 1);
    hold(18, 0, 0, 0);
    tick(1, 0, 0, 1);
    hold(18, 0, 0, 0);

    tick(0, 0, 1, 0);
    hold(40, 0, 0, 1);

    for (int i = 0; i < 500; i++)
      tick($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0);

    hold(6, 0, 1, 0);
    tick(0, 0, 1, 0);
    run_until(4, 0);
    @(negedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    e = snap();
    chk("async_reset", e);
    repeat (2) @(negedge clk);
    cur = e;
    reset_n = 1'b1;
    hold(3, 0, 0, 0);
    tick(0, 0, 1, 0);
    hold(25, 0, 0, 0);

    repeat (3) @(negedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d left want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
